led_cmd_engine: RTL and testbench
=================================

Name: led_cmd_engine

Overview:
- Downstream consumer of the SPI slave byte stream (`cmd[7:0]` / `cmd_valid`).
- Parses one- and two-byte LED commands, holds per-LED duty and blink settings, and drives `NUM_LEDS` registered LED outputs with 8-bit PWM and optional blink gating.
- Replaces the direct `cmd & 1` LED hookup in the top level.

Parameters:
- `NUM_LEDS`, 4: LED channels, legal range 1..16.
- `PWM_DIV`, 1: clocks per PWM counter step, ≥1.
- `BLINK_WIDTH`, 24: free-running blink counter width, ≥8.

Ports:
- `clk` in 1: system clock (PLL output).
- `rst` in 1: asynchronous, active-high reset.
- `cmd_byte` in 8: received SPI byte.
- `cmd_valid` in 1: one-cycle strobe, `cmd_byte` valid.
- `frame_end` in 1: one-cycle strobe at SSEL deassertion; resynchronises the parser.
- `led_out` out `NUM_LEDS`: registered LED drive, 1 = on.
- `cmd_done` out 1: one-cycle pulse when a command has been applied.
- `err_count` out 8: saturating protocol error count.

Behaviour:
- Reset (async, `rst`=1):
  - all `duty[i]`=0, `blink[i]`=0, `led_out`=0, `cmd_done`=0, `err_count`=0.
  - state IDLE; PWM, prescaler and blink counters 0.
- Header byte: [7:4]=op, [3:0]=idx.
  - op 0x0 NOP: 1 byte, no effect, `cmd_done` pulses.
  - op 0x1 SET_DUTY: 2 bytes; data byte written to `duty[idx]`.
  - op 0x2 SET_BLINK: 2 bytes; data[2:0] written to `blink[idx]`, data[7:3] ignored.
  - op 0xF CLEAR_ALL: 1 byte; all duty/blink cleared, idx ignored, `cmd_done` pulses.
  - any other op: 1 byte, ignored, `err_count`+1, no `cmd_done`.
- FSM:
  - IDLE --header of a 2-byte op--> WAIT_DATA (latch op, idx).
  - WAIT_DATA --`cmd_valid`--> apply, IDLE.
  - 1-byte ops stay in IDLE.
- idx ≥ `NUM_LEDS` on a 2-byte op: data byte consumed and discarded, `err_count`+1, no `cmd_done`.
- Apply timing:
  - register write on the edge sampling the final byte.
  - `cmd_done` high and `led_out` reflecting the new setting on the following cycle (1-cycle latency).
- `frame_end`:
  - in IDLE: no effect.
  - in WAIT_DATA: abort the pending command, IDLE, `err_count`+1.
- `cmd_valid` and `frame_end` in the same cycle:
  - the byte is processed first.
  - if that byte completes a command, the command is applied and there is no error.
  - if that byte is a 2-byte header, it is aborted (IDLE, `err_count`+1).
- `err_count` saturates at 0xFF and never wraps.
- PWM:
  - prescaler counts 0..`PWM_DIV`-1; `pwm_cnt` (8 bit) increments on prescaler wrap and wraps 255→0.
  - `pwm_on[i]` = (`pwm_cnt` < `duty[i]`). duty 0 = always off; duty 255 = on 255 of every 256 steps.
- Blink:
  - `blink_cnt` (`BLINK_WIDTH` bit) increments every clock and wraps.
  - `blink[i]`=0 → gate=1.
  - `blink[i]`=k (1..7) → gate = `blink_cnt[BLINK_WIDTH-8+k]`.
- `led_out[i]` <= `pwm_on[i]` & gate[i], registered every clock.
- Reset asserted mid-command discards any partial command. No byte is lost across commands: back-to-back `cmd_valid` on consecutive cycles is legal.

Test Plan:
- Reset then idle 1024 clocks (`PWM_DIV`=1) → `led_out`=0, `err_count`=0, `cmd_done` never high.
- Send 0x10, 0x80 → `cmd_done` 1 cycle after the 0x80 strobe; `led_out[0]` high exactly 128 of every 256 clocks. Then 0x10, 0xFF → 255/256. Then 0x10, 0x00 → always low.
- With `BLINK_WIDTH`=10: send 0x11, 0xFF then 0x21, 0x01 → `led_out[1]` follows PWM only while `blink_cnt[3]`=1 (8-clock windows). Then 0xF0 → all `led_out` 0 within 1 cycle.
- Errors:
  - 0x15, 0x40 with `NUM_LEDS`=4 → no LED change, `err_count`=1.
  - header 0x7x → `err_count`=2.
  - 0x12 then `frame_end` → `err_count`=3, parser in IDLE.
  - next 0x12, 0x20 → `led_out[2]` duty 32/256.
- Same-cycle: `cmd_valid`+`frame_end` with the data byte 0x40 after header 0x13 → applied, no error. With header 0x13 alone → aborted, `err_count`+1.
- 300 invalid headers → `err_count` stops at 0xFF. Assert `rst` in WAIT_DATA → all outputs 0 immediately (async). After release, 0x10, 0x80 works normally.

Source files
------------

// File: rtl/led_cmd_engine_if.sv
// Byte-stream command bus between the SPI receiver and the LED command engine.
// Latency: none (wires only).
// Backpressure: none; the consumer must accept a byte on every cmd_valid strobe.
interface led_cmd_engine_if #(
    parameter int NUM_LEDS = 4
);
    logic [7:0]          cmd_byte;
    logic                cmd_valid;
    logic                frame_end;
    logic [NUM_LEDS-1:0] led_out;
    logic                cmd_done;
    logic [7:0]          err_count;

    // Byte source (SPI slave side)
    modport master (
        output cmd_byte, cmd_valid, frame_end,
        input  led_out, cmd_done, err_count
    );

    // Command consumer (LED engine side)
    modport slave (
        input  cmd_byte, cmd_valid, frame_end,
        output led_out, cmd_done, err_count
    );
endinterface

// File: rtl/led_cmd_engine.sv
// Parses 1/2-byte LED commands and drives per-LED 8-bit PWM with optional blink gating.
// Latency: command applied on the edge sampling its final byte; cmd_done/led_out reflect it 1 cycle later.
// Backpressure: none; a byte is accepted on every cmd_valid, back-to-back strobes included.
module led_cmd_engine #(
    parameter int NUM_LEDS    = 4,
    parameter int PWM_DIV     = 1,
    parameter int BLINK_WIDTH = 24
) (
    input  logic            clk,
    input  logic            rst,
    led_cmd_engine_if.slave bus
);
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    typedef enum logic {IDLE, WAIT_DATA} state_t;

    state_t                 state;
    logic [3:0]             op_q;
    logic [3:0]             idx_q;
    logic [7:0]             err_count;
    logic                   cmd_done;
    logic [NUM_LEDS-1:0]    led_out;
    logic [7:0]             duty     [NUM_LEDS];
    logic [2:0]             blink    [NUM_LEDS];
    logic [7:0]             duty_eff [NUM_LEDS];
    logic [2:0]             blink_eff[NUM_LEDS];
    logic [NUM_LEDS-1:0]    gate;
    logic [PW-1:0]          presc;
    logic [7:0]             pwm_cnt;
    logic [BLINK_WIDTH-1:0] blink_cnt;

    logic [3:0] hdr_op;
    logic [3:0] hdr_idx;
    logic       idx_ok;
    logic       wr_duty;
    logic       wr_blink;
    logic       wr_clear;

    assign hdr_op  = bus.cmd_byte[7:4];
    assign hdr_idx = bus.cmd_byte[3:0];
    assign idx_ok  = ({1'b0, idx_q} < 5'(NUM_LEDS));

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decode the register write implied by this cycle's byte
    always_comb begin
        wr_duty  = 1'b0;
        wr_blink = 1'b0;
        wr_clear = 1'b0;
        if (bus.cmd_valid) begin
            if (state == IDLE) begin
                wr_clear = (hdr_op == 4'hF);
            end else if (idx_ok) begin
                wr_duty  = (op_q == 4'h1);
                wr_blink = (op_q == 4'h2);
            end
        end
    end

    // Settings as they will be after this edge; LED drive uses these so it tracks cmd_done
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty_eff[i]  = duty[i];
            blink_eff[i] = blink[i];
            if (wr_clear) begin
                duty_eff[i]  = 8'd0;
                blink_eff[i] = 3'd0;
            end else if (idx_q == 4'(i)) begin
                if (wr_duty)  duty_eff[i]  = bus.cmd_byte;
                if (wr_blink) blink_eff[i] = bus.cmd_byte[2:0];
            end
            gate[i] = (blink_eff[i] == 3'd0) ? 1'b1
                    : blink_cnt[BLINK_WIDTH - 8 + int'(blink_eff[i])];
        end
    end

    // Command parser FSM; same-cycle frame_end aborts only a freshly received 2-byte header
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= 4'd0;
            idx_q     <= 4'd0;
            err_count <= 8'd0;
            cmd_done  <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        case (hdr_op)
                            4'h0, 4'hF: cmd_done <= 1'b1;
                            4'h1, 4'h2: begin
                                op_q  <= hdr_op;
                                idx_q <= hdr_idx;
                                if (bus.frame_end) err_count <= sat_inc(err_count);
                                else               state     <= WAIT_DATA;
                            end
                            default: err_count <= sat_inc(err_count);
                        endcase
                    end
                end
                WAIT_DATA: begin
                    if (bus.cmd_valid) begin
                        state <= IDLE;
                        if (idx_ok) cmd_done  <= 1'b1;
                        else        err_count <= sat_inc(err_count);
                    end else if (bus.frame_end) begin
                        state     <= IDLE;
                        err_count <= sat_inc(err_count);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-LED duty and blink settings
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty[i]  <= 8'd0;
                blink[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty[i]  <= duty_eff[i];
                blink[i] <= blink_eff[i];
            end
        end
    end

    // PWM prescaler/counter and free-running blink counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            pwm_cnt   <= 8'd0;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (presc == PW'(PWM_DIV - 1)) begin
                presc   <= '0;
                pwm_cnt <= pwm_cnt + 8'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Registered LED drive: PWM compare gated by blink
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++)
                led_out[i] <= (pwm_cnt < duty_eff[i]) & gate[i];
        end
    end

    assign bus.led_out   = led_out;
    assign bus.cmd_done  = cmd_done;
    assign bus.err_count = err_count;
endmodule

// File: tb/tb_led_cmd_engine.sv
// Self-checking bench for led_cmd_engine with a cmd_done scoreboard.
// Latency: expects cmd_done on the cycle after the final byte is sampled.
// Backpressure: none; bytes are driven on consecutive cycles where useful.
module tb_led_cmd_engine;
    localparam int NUM_LEDS    = 4;
    localparam int PWM_DIV     = 1;
    localparam int BLINK_WIDTH = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_q[$];

    led_cmd_engine_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    led_cmd_engine #(
        .NUM_LEDS(NUM_LEDS),
        .PWM_DIV(PWM_DIV),
        .BLINK_WIDTH(BLINK_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release; equals the DUT blink counter
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard: each cmd_done must match the cycle recorded when its final byte went in
    always @(negedge clk) begin
        if (!rst && bus.cmd_done === 1'b1) begin
            if (done_q.size() == 0) check("done_unexpected", 1, 0);
            else                    check("done_cycle", cyc, done_q.pop_front());
        end
    end

    // Present one bus cycle; called and returns 1ns after a rising edge
    task automatic drive(input logic [7:0] b, input logic v, input logic fe);
        bus.cmd_byte  = b;
        bus.cmd_valid = v;
        bus.frame_end = fe;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.frame_end = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic fe, input bit expect_done);
        drive(b, 1'b1, fe);
        if (expect_done) done_q.push_back(cyc);
    endtask

    task automatic cmd2(input logic [7:0] h, input logic [7:0] d);
        send(h, 1'b0, 1'b0);
        send(d, 1'b0, 1'b1);
    endtask

    task automatic count_on(input int idx, input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.led_out[idx]) ones++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ones;
        int bad;
        int exp_led;
        int pc;
        int bc;

        bus.cmd_byte  = 8'd0;
        bus.cmd_valid = 1'b0;
        bus.frame_end = 1'b0;

        #12;
        check("rst_led", int'(bus.led_out), 0);
        check("rst_err", int'(bus.err_count), 0);
        check("rst_done", int'(bus.cmd_done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle: nothing lights, no errors
        bad = 0;
        repeat (1024) begin
            @(negedge clk);
            if (bus.led_out != '0) bad++;
        end
        @(posedge clk);
        #1;
        check("idle_led_cycles", bad, 0);
        check("idle_err", int'(bus.err_count), 0);

        // NOP produces only cmd_done
        send(8'h00, 1'b0, 1'b1);

        // Duty sweep on LED 0
        cmd2(8'h10, 8'h80);
        count_on(0, 256, ones);
        check("duty128", ones, 128);
        cmd2(8'h10, 8'hFF);
        count_on(0, 256, ones);
        check("duty255", ones, 255);
        cmd2(8'h10, 8'h00);
        count_on(0, 256, ones);
        check("duty0", ones, 0);

        // Blink on LED 1: PWM 255 gated by blink_cnt[3]
        cmd2(8'h11, 8'hFF);
        cmd2(8'h21, 8'h01);
        bad = 0;
        ones = 0;
        repeat (512) begin
            @(negedge clk);
            pc = (cyc - 1) & 255;
            bc = cyc - 1;
            exp_led = ((pc < 255) && (((bc >> 3) & 1) == 1)) ? 1 : 0;
            if (int'(bus.led_out[1]) != exp_led) bad++;
            ones += int'(bus.led_out[1]);
        end
        @(posedge clk);
        #1;
        check("blink_mismatch_cycles", bad, 0);
        check("blink_on_cycles", ones, 254);

        // Clear all
        send(8'hF0, 1'b0, 1'b1);
        @(negedge clk);
        check("clear_led", int'(bus.led_out), 0);
        @(posedge clk);
        #1;

        // Protocol errors
        cmd2(8'h15, 8'h40);
        done_q.pop_back();
        check("err_bad_idx", int'(bus.err_count), 1);
        count_on(0, 256, ones);
        check("bad_idx_no_led", ones, 0);
        send(8'h73, 1'b0, 1'b0);
        check("err_bad_op", int'(bus.err_count), 2);
        send(8'h12, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b1);
        check("err_frame_abort", int'(bus.err_count), 3);
        cmd2(8'h12, 8'h20);
        count_on(2, 256, ones);
        check("duty32_led2", ones, 32);

        // Same-cycle data byte and frame_end: applied, no error
        send(8'h13, 1'b0, 1'b0);
        send(8'h40, 1'b1, 1'b1);
        check("same_cycle_data_err", int'(bus.err_count), 3);
        count_on(3, 256, ones);
        check("same_cycle_duty64", ones, 64);

        // Same-cycle header and frame_end: aborted, parser back in IDLE
        send(8'h13, 1'b1, 1'b0);
        check("same_cycle_hdr_err", int'(bus.err_count), 4);
        send(8'h30, 1'b0, 1'b0);
        check("post_abort_idle_err", int'(bus.err_count), 5);
        count_on(3, 256, ones);
        check("post_abort_duty", ones, 64);

        // Saturation with back-to-back invalid headers
        bus.cmd_byte  = 8'h50;
        bus.cmd_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("err_saturate", int'(bus.err_count), 255);

        // Async reset while waiting for a data byte
        send(8'h12, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_err", int'(bus.err_count), 0);
        check("async_rst_led", int'(bus.led_out), 0);
        check("async_rst_done", int'(bus.cmd_done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cmd2(8'h10, 8'h80);
        count_on(0, 256, ones);
        check("post_rst_duty128", ones, 128);
        count_on(3, 256, ones);
        check("post_rst_led3_cleared", ones, 0);
        check("post_rst_err", int'(bus.err_count), 0);

        repeat (4) @(posedge clk);
        check("done_queue_empty", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
